// File: rtl/timer_8_bit_arbiter_pkg.sv
// Shared types and constants for the timer arbiter: FSM state encoding,
// default timer width, the fixed one-shot mode and a modulo increment helper.
package timer_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_STOP  = 3'd4,
      ST_DRAIN = 3'd5
   } timer_arb_state_t;

   localparam int   TIMER_W_DEF  = 8;
   localparam logic MODE_ONESHOT = 1'b0;

   // Next index after idx, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/timer_8_bit_arbiter_if.sv
// Requester and timer-command bus of the arbiter. The arbiter holds the master
// modport; requesters and the shared timer sit behind the slave modport.
// Handshake: Req_In is a level that the requester holds until its Done_Out
// pulse (or drops early to cancel); Grant_Out marks ownership, Done_Out is a
// single-cycle completion strobe to the owner only.
interface timer_8_bit_arbiter_if
   import timer_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMER_W = TIMER_W_DEF
) ();

   logic [NUM_REQ-1:0]         Req_In;
   logic [NUM_REQ*TIMER_W-1:0] Req_Preload_In;
   logic [NUM_REQ-1:0]         Grant_Out;
   logic [NUM_REQ-1:0]         Done_Out;
   logic                       Busy_Out;
   logic                       Timer_Enable_Out;
   logic                       Timer_Start_Cmd_Out;
   logic                       Timer_Stop_Cmd_Out;
   logic                       Timer_Mode_Out;
   logic [TIMER_W-1:0]         Timer_Preload_Out;
   logic                       Timer_Running_Flag_In;
   logic                       Timer_Rollover_Flag_In;

   modport master (
      input  Req_In, Req_Preload_In, Timer_Running_Flag_In, Timer_Rollover_Flag_In,
      output Grant_Out, Done_Out, Busy_Out, Timer_Enable_Out, Timer_Start_Cmd_Out,
             Timer_Stop_Cmd_Out, Timer_Mode_Out, Timer_Preload_Out
   );

   modport slave (
      output Req_In, Req_Preload_In, Timer_Running_Flag_In, Timer_Rollover_Flag_In,
      input  Grant_Out, Done_Out, Busy_Out, Timer_Enable_Out, Timer_Start_Cmd_Out,
             Timer_Stop_Cmd_Out, Timer_Mode_Out, Timer_Preload_Out
   );

endinterface

// File: rtl/timer_8_bit_arbiter_round_robin_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping past the top, returned as one-hot and as an index.
module round_robin_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      int cur;
      cur     = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int off = 0; off < N; off++) begin
         cur = int'(ptr_i) + off;
         if (cur >= N) cur = cur - N;
         if (!valid_o && req_i[IDX_W'(cur)]) begin
            valid_o               = 1'b1;
            gnt_o[IDX_W'(cur)]    = 1'b1;
            idx_o                 = IDX_W'(cur);
         end
      end
   end

endmodule

// File: rtl/timer_8_bit_arbiter.sv
// Shares one one-shot timer between NUM_REQ requesters: round-robin grant,
// start/stop command sequencing and a completion pulse back to the owner.
module timer_8_bit_arbiter
   import timer_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMER_W = TIMER_W_DEF
) (
   input  logic                   Clk_In,
   input  logic                   Reset_n_In,
   timer_8_bit_arbiter_if.master  bus,
   output timer_arb_state_t       State_Dbg_Out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   timer_arb_state_t   state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               busy_q, busy_d;
   logic               start_q, start_d;
   logic               stop_q, stop_d;
   logic               en_q;
   logic [TIMER_W-1:0] preload_q, preload_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic               req_granted;

   round_robin_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i   (bus.Req_In),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Owner still wants the timer; a drop here is a cancel.
   assign req_granted = |(grant_q & bus.Req_In);

   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         en_q      <= 1'b0;
         preload_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         en_q      <= 1'b1;
         preload_q <= preload_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (arb_valid) state_d = ST_START;
         ST_START: state_d = ST_ARMED;
         ST_ARMED: begin
            if (!req_granted)                    state_d = ST_STOP;
            else if (bus.Timer_Running_Flag_In)  state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.Timer_Rollover_Flag_In) state_d = ST_IDLE;
            else if (!req_granted)          state_d = ST_STOP;
         end
         ST_STOP:  state_d = ST_DRAIN;
         ST_DRAIN: if (!bus.Timer_Running_Flag_In) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Registered outputs: each _d is what the output shows after the next edge.
   always_comb begin
      grant_d   = grant_q;
      preload_d = preload_q;
      ptr_d     = ptr_q;
      done_d    = '0;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d   = arb_gnt;
               preload_d = bus.Req_Preload_In[int'(arb_idx)*TIMER_W +: TIMER_W];
               ptr_d     = IDX_W'(wrap_inc(int'(arb_idx), NUM_REQ));
            end
         end
         ST_START: start_d = 1'b1;
         ST_ARMED: if (!req_granted) grant_d = '0;
         ST_RUN: begin
            if (bus.Timer_Rollover_Flag_In) begin
               done_d  = grant_q;
               grant_d = '0;
            end else if (!req_granted) begin
               grant_d = '0;
            end
         end
         ST_STOP:  stop_d = 1'b1;
         ST_DRAIN: ;
         default:  ;
      endcase
   end

   assign bus.Grant_Out           = grant_q;
   assign bus.Done_Out            = done_q;
   assign bus.Busy_Out            = busy_q;
   assign bus.Timer_Enable_Out    = en_q;
   assign bus.Timer_Start_Cmd_Out = start_q;
   assign bus.Timer_Stop_Cmd_Out  = stop_q;
   assign bus.Timer_Mode_Out      = MODE_ONESHOT;
   assign bus.Timer_Preload_Out   = preload_q;
   assign State_Dbg_Out           = state_q;

endmodule

// File: tb/tb_timer_8_bit_arbiter.sv
// Bench for timer_8_bit_arbiter: behavioural one-shot timer, a done scoreboard
// keyed by expected cycle, a table of single requests and corner sequences.
module tb_timer_8_bit_arbiter;
   import timer_arb_pkg::*;

   localparam int NR = 4;
   localparam int TW = 8;
   localparam int EW = NR + 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   stop_cnt = 0;
   logic [EW-1:0] exp_q[$];
   timer_arb_state_t state_dbg;

   logic [TW-1:0] tmr_cnt;
   logic          tmr_run;
   logic          tmr_roll;

   typedef struct {
      int idx;
      int preload;
      bit chg;
   } vec_t;
   vec_t vecs[6];

   timer_8_bit_arbiter_if #(.NUM_REQ(NR), .TIMER_W(TW)) bus ();

   timer_8_bit_arbiter #(.NUM_REQ(NR), .TIMER_W(TW)) dut (
      .Clk_In        (clk),
      .Reset_n_In    (rst_n),
      .bus           (bus),
      .State_Dbg_Out (state_dbg)
   );

   // clock / reset / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // shared one-shot timer model
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt  <= '0;
         tmr_run  <= 1'b0;
         tmr_roll <= 1'b0;
      end else begin
         tmr_roll <= 1'b0;
         if (bus.Timer_Start_Cmd_Out) begin
            tmr_cnt <= bus.Timer_Preload_Out;
            tmr_run <= 1'b1;
         end else if (bus.Timer_Stop_Cmd_Out) begin
            tmr_run <= 1'b0;
         end else if (tmr_run && bus.Timer_Enable_Out) begin
            if (tmr_cnt == 0) begin
               tmr_roll <= 1'b1;
               tmr_run  <= 1'b0;
            end else begin
               tmr_cnt <= tmr_cnt - 1'b1;
            end
         end
      end
   end
   assign bus.Timer_Running_Flag_In  = tmr_run;
   assign bus.Timer_Rollover_Flag_In = tmr_roll;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard: every done pulse must match the head of exp_q, cycle included
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.Done_Out != '0) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'(bus.Done_Out), 32'd0);
            end else begin
               check("done", 32'({bus.Done_Out, 16'(cyc)}), 32'(exp_q.pop_front()));
            end
         end
         if (bus.Timer_Stop_Cmd_Out) stop_cnt++;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.Req_In = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.Done_Out != '0) seen = 1'b1;
      end
      check("done_timeout", 32'(seen), 32'd1);
   endtask

   task automatic run_single(input int idx, input int p, input bit chg);
      int c;
      logic [NR-1:0] oh;
      oh = NR'(1 << idx);
      c  = cyc;
      bus.Req_Preload_In[idx*TW +: TW] = TW'(p);
      bus.Req_In = oh;
      exp_q.push_back({oh, 16'(c + 5 + p)});
      @(negedge clk);
      check("grant", 32'(bus.Grant_Out), 32'(oh));
      check("grant_preload", 32'(bus.Timer_Preload_Out), 32'(p));
      check("busy_on_grant", 32'(bus.Busy_Out), 32'd1);
      if (chg) bus.Req_Preload_In = ~bus.Req_Preload_In;
      @(negedge clk);
      check("start_pulse", 32'(bus.Timer_Start_Cmd_Out), 32'd1);
      @(negedge clk);
      check("start_single", 32'(bus.Timer_Start_Cmd_Out), 32'd0);
      check("preload_hold", 32'(bus.Timer_Preload_Out), 32'(p));
      wait_done(300);
      bus.Req_In = '0;
      check("busy_after_done", 32'(bus.Busy_Out), 32'd0);
      @(negedge clk);
      check("idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int c;
      int t;
      int d;
      int s0;
      int fp[4];
      int ord[5];

      vecs[0] = '{idx: 0, preload: 5,   chg: 1'b0};
      vecs[1] = '{idx: 2, preload: 0,   chg: 1'b0};
      vecs[2] = '{idx: 3, preload: 255, chg: 1'b0};
      vecs[3] = '{idx: 1, preload: 17,  chg: 1'b1};
      vecs[4] = '{idx: 0, preload: 1,   chg: 1'b0};
      vecs[5] = '{idx: 2, preload: 128, chg: 1'b0};
      fp  = '{3, 2, 1, 0};
      ord = '{0, 1, 2, 3, 0};

      bus.Req_In = '0;
      bus.Req_Preload_In = '0;

      // reset state
      @(negedge clk);
      check("rst_grant", 32'(bus.Grant_Out), 32'd0);
      check("rst_done", 32'(bus.Done_Out), 32'd0);
      check("rst_busy", 32'(bus.Busy_Out), 32'd0);
      check("rst_start", 32'(bus.Timer_Start_Cmd_Out), 32'd0);
      check("rst_stop", 32'(bus.Timer_Stop_Cmd_Out), 32'd0);
      check("rst_preload", 32'(bus.Timer_Preload_Out), 32'd0);
      check("rst_mode", 32'(bus.Timer_Mode_Out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("enable_after_rst", 32'(bus.Timer_Enable_Out), 32'd1);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

      // table of single requests (includes preload 0 then 255)
      for (int i = 0; i < 6; i++) run_single(vecs[i].idx, vecs[i].preload, vecs[i].chg);

      // fairness: all four held, order 0,1,2,3,0 from pointer 0
      do_reset();
      for (int i = 0; i < NR; i++) bus.Req_Preload_In[i*TW +: TW] = TW'(fp[i]);
      c = cyc;
      t = c + 1;
      for (int i = 0; i < 5; i++) begin
         d = t + 4 + fp[ord[i]];
         exp_q.push_back({NR'(1 << ord[i]), 16'(d)});
         t = d + 1;
      end
      bus.Req_In = '1;
      @(negedge clk);
      check("fair_grant0", 32'(bus.Grant_Out), 32'd1);
      for (int i = 0; i < 5; i++) begin
         wait_done(50);
         if (i == 4) begin
            bus.Req_In = '0;
         end else begin
            @(negedge clk);
            check("fair_grant", 32'(bus.Grant_Out), 32'(1 << ord[i+1]));
         end
      end
      repeat (3) @(negedge clk);

      // cancel: preload 15, drop four cycles after grant
      s0 = stop_cnt;
      bus.Req_Preload_In[0 +: TW] = 8'd15;
      bus.Req_In = 4'b0001;
      repeat (5) @(negedge clk);
      check("cancel_busy_run", 32'(bus.Busy_Out), 32'd1);
      bus.Req_In = '0;
      @(negedge clk);
      check("cancel_grant_clr", 32'(bus.Grant_Out), 32'd0);
      check("cancel_stop_lo", 32'(bus.Timer_Stop_Cmd_Out), 32'd0);
      @(negedge clk);
      check("cancel_stop_hi", 32'(bus.Timer_Stop_Cmd_Out), 32'd1);
      @(negedge clk);
      check("cancel_stop_end", 32'(bus.Timer_Stop_Cmd_Out), 32'd0);
      check("cancel_tmr_stopped", 32'(tmr_run), 32'd0);
      check("cancel_busy_drain", 32'(bus.Busy_Out), 32'd1);
      @(negedge clk);
      check("cancel_busy_idle", 32'(bus.Busy_Out), 32'd0);
      repeat (20) @(negedge clk);
      check("cancel_stop_count", 32'(stop_cnt - s0), 32'd1);

      // race: drop request in the cycle rollover is high
      s0 = stop_cnt;
      bus.Req_Preload_In[1*TW +: TW] = 8'd3;
      c = cyc;
      bus.Req_In = 4'b0010;
      exp_q.push_back({4'b0010, 16'(c + 8)});
      repeat (7) @(negedge clk);
      check("race_rollover_hi", 32'(tmr_roll), 32'd1);
      bus.Req_In = '0;
      wait_done(10);
      repeat (5) @(negedge clk);
      check("race_no_stop", 32'(stop_cnt - s0), 32'd0);

      // asynchronous reset mid-RUN
      bus.Req_Preload_In[0 +: TW] = 8'd50;
      bus.Req_In = 4'b0001;
      repeat (6) @(negedge clk);
      check("midrun_state", 32'(state_dbg), 32'(ST_RUN));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(bus.Grant_Out), 32'd0);
      check("arst_busy", 32'(bus.Busy_Out), 32'd0);
      check("arst_done", 32'(bus.Done_Out), 32'd0);
      check("arst_preload", 32'(bus.Timer_Preload_Out), 32'd0);
      check("arst_enable", 32'(bus.Timer_Enable_Out), 32'd0);
      check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
      bus.Req_In = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_single(2, 7, 1'b0);

      // pointer restarts at 0 after reset: 1010 must go to requester 1
      do_reset();
      bus.Req_Preload_In[1*TW +: TW] = 8'd4;
      bus.Req_Preload_In[3*TW +: TW] = 8'd6;
      c = cyc;
      bus.Req_In = 4'b1010;
      exp_q.push_back({4'b0010, 16'(c + 9)});
      @(negedge clk);
      check("ptr_reset_grant", 32'(bus.Grant_Out), 32'b0010);
      wait_done(30);
      bus.Req_In = '0;

      repeat (10) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/timer_8_bit_arbiter.md
# timer_8_bit_arbiter

- Shares one `Timer_8_Bit` instance between `NUM_REQ` requesters.
- Each requester asks for a one-shot delay with its own 8-bit preload.
- The block grants requesters round-robin, sequences the timer's start/stop commands, and returns a completion pulse to the granted requester.
- It sits between requester FSMs and the timer, and is the only driver of the timer's command inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMER_W`, 8: preload/count width; must match the timer.
- `Clk_In`  in  1  clock; all state changes on the rising edge.
- `Reset_n_In`  in  1  reset, asynchronous, active-low.
- `Req_In`  in  NUM_REQ  level request per requester; held until that requester's `Done_Out` or until it cancels.
- `Req_Preload_In`  in  NUM_REQ*TIMER_W  packed preloads; slice i is `[i*TIMER_W +: TIMER_W]`.
- `Grant_Out`  out  NUM_REQ  one-hot; the requester currently owning the timer.
- `Done_Out`  out  NUM_REQ  one-cycle pulse to the granted requester on expiry.
- `Busy_Out`  out  1  high whenever the FSM is not in IDLE.
- `Timer_Enable_Out`  out  1  timer enable.
- `Timer_Start_Cmd_Out`  out  1  to timer `Start_Timer_Command_In`.
- `Timer_Stop_Cmd_Out`  out  1  to timer `Stop_Timer_Command_In`.
- `Timer_Mode_Out`  out  1  to timer `Timer_Periodic_Oneshotb_Mode_In`; constant 0 (one-shot).
- `Timer_Preload_Out`  out  TIMER_W  to timer `Preload_Timer_Value_In`.
- `Timer_Running_Flag_In`  in  1  from timer.
- `Timer_Rollover_Flag_In`  in  1  from timer.

## Operation
- **Reset values:**
  - `Grant_Out`, `Done_Out`, `Busy_Out`, both command outputs and `Timer_Preload_Out` = 0.
  - `Timer_Enable_Out` = 1 from the first edge after reset release.
  - `Timer_Mode_Out` = 0.
  - Round-robin pointer = 0; FSM = IDLE.
- **FSM states:** IDLE, START, ARMED, RUN, STOP, DRAIN. All outputs are registered.
- **IDLE:**
  - If any `Req_In` bit is set, pick the first set bit at or after the pointer (wrapping).
  - Register the one-hot grant and `Timer_Preload_Out` = that requester's preload slice.
  - Set the pointer to winner+1 mod `NUM_REQ`, then go to START.
- **START:**
  - `Timer_Start_Cmd_Out` = 1 for exactly this cycle; go to ARMED.
  - Cancellation is not checked in START.
- **ARMED:**
  - Go to RUN when `Timer_Running_Flag_In` = 1.
  - Go to STOP if the granted `Req_In` = 0.
- **RUN:**
  - On `Timer_Rollover_Flag_In` = 1: pulse `Done_Out[g]`, clear the grant, go to IDLE.
  - Otherwise, if the granted `Req_In` = 0: go to STOP.
- **STOP:**
  - Grant is cleared on entry.
  - `Timer_Stop_Cmd_Out` = 1 for one cycle; go to DRAIN.
  - No `Done_Out` pulse.
- **DRAIN:** go to IDLE when `Timer_Running_Flag_In` = 0.
- **Preload and grant stability:**
  - `Timer_Preload_Out` is held constant from grant until return to IDLE.
  - Changes on `Req_Preload_In` after grant are ignored.
- **Simultaneous events:**
  - Rollover and request drop in the same cycle: rollover wins and `Done_Out` pulses.
  - Several requests in IDLE: only one is granted; the others wait, and fairness comes from the pointer.
- **Back-to-back requests:** a requester whose `Req_In` is still high in the cycle after `Done_Out` is a new request. Because the pointer has moved past it, other pending requesters are served first.
- **Preload 0:** rollover arrives one cycle after the timer loads; handled with no special case.
- **Reset mid-operation:** all outputs return to reset values immediately; no `Done_Out` pulse. The timer is reset by its own reset.

## Timing
- IDLE sees `Req_In` at edge k:
  - `Grant_Out`/`Timer_Preload_Out` are valid after edge k.
  - `Timer_Start_Cmd_Out` is high between edges k+1 and k+2.
- The timer loads P at edge k+2 and its rollover is seen at edge k+3+P. `Done_Out` is high between edges k+4+P and k+5+P.
- Request-to-done latency is P+4 cycles.
- The next grant can be issued at edge k+5+P, the first IDLE edge.
- Cancel: the request drop seen at edge m (ARMED/RUN) gives `Timer_Stop_Cmd_Out` high between edges m+1 and m+2, and IDLE at edge m+3.

## Structure
- Package `timer_arb_pkg`:
  - state enum `timer_arb_state_t`;
  - `TIMER_W_DEF` = 8;
  - `MODE_ONESHOT` = 1'b0.
- Sub-module `round_robin_arbiter`:
  - combinational pick of the first set bit from the pointer, with wrap;
  - outputs one-hot grant and index.
- The top-level module holds the FSM and the pointer register.

## Test plan
- **Single request:** reset, `Req_In`=0001, preload 5 -> `Start_Cmd` pulse at k+1, `Done_Out`=0001 pulse at k+9, `Busy_Out` low after.
- **Fairness:** `Req_In`=1111 held, preloads 3/2/1/0 -> grant order 0,1,2,3,0. Each grant has exactly one `Done_Out` pulse.
- **Cancel:** preload 15, drop `Req_In[0]` 4 cycles after grant -> one `Stop_Cmd` pulse, no `Done_Out`, timer running 0, `Busy_Out` 0 two cycles later.
- **Race:** drop `Req_In[1]` in the exact cycle rollover is high -> `Done_Out[1]` pulses and no `Stop_Cmd` is issued.
- **Preload 0 followed by preload 255:** latencies are 4 and 259 cycles; the timer count never wraps below 0.
- **Reset:** deassert `Reset_n_In` mid-RUN -> all outputs 0 asynchronously. After release, `Req_In`=0100 is granted starting from pointer 0.
